// File: rtl/lector_contador.sv
// lector_contador: reads four counters in turn over a request/valid handshake and latches each count.
// Optional build macro LECTOR_CONTADOR_TIMEOUT_EN adds a per-response WAIT watchdog with a sticky error flag.
module lector_contador #(
  parameter int WIDTH   = 6,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             valid,
  input  logic [WIDTH-1:0] contador_in,
  output logic             request,
  output logic [1:0]       idx,
  output logic [WIDTH-1:0] cuenta0,
  output logic [WIDTH-1:0] cuenta1,
  output logic [WIDTH-1:0] cuenta2,
  output logic [WIDTH-1:0] cuenta3,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  // The watchdog compares against TIMEOUT-1, so a zero timeout has no meaning.
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("lector_contador: TIMEOUT must be at least 1");
  end

  state_t           state_q, state_d;
  logic             request_q, request_d;
  logic [1:0]       idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] cuenta_q [4];
  logic [WIDTH-1:0] cuenta_d [4];
  logic             resp_end;
  logic [WIDTH-1:0] resp_val;

`ifdef LECTOR_CONTADOR_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          error_q, error_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cuenta_d = cuenta_q;
    resp_end = 1'b0;
    resp_val = '0;
`ifdef LECTOR_CONTADOR_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    error_d    = error_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = 2'd0;
          state_d = ST_REQ;
`ifdef LECTOR_CONTADOR_TIMEOUT_EN
          error_d = 1'b0;
`endif
        end
      end

      ST_REQ: begin
        state_d = ST_WAIT;
`ifdef LECTOR_CONTADOR_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      ST_WAIT: begin
        if (valid) begin
          resp_end = 1'b1;
          resp_val = contador_in;
        end
`ifdef LECTOR_CONTADOR_TIMEOUT_EN
        else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          // A response arriving on the expiry cycle takes the valid branch above.
          if (wait_cnt_q == CNT_LAST) begin
            resp_end = 1'b1;
            resp_val = '0;
            error_d  = 1'b1;
          end
        end
`endif
        if (resp_end) begin
          cuenta_d[idx_q] = resp_val;
          if (idx_q == 2'd3) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_REQ;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    request_d = (state_d == ST_REQ);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      request_q <= 1'b0;
      idx_q     <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cuenta_q[i] <= '0;
      end
`ifdef LECTOR_CONTADOR_TIMEOUT_EN
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      request_q <= request_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      for (int i = 0; i < 4; i++) begin
        cuenta_q[i] <= cuenta_d[i];
      end
`ifdef LECTOR_CONTADOR_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      error_q    <= error_d;
`endif
    end
  end

  assign request = request_q;
  assign idx     = idx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cuenta0 = cuenta_q[0];
  assign cuenta1 = cuenta_q[1];
  assign cuenta2 = cuenta_q[2];
  assign cuenta3 = cuenta_q[3];

`ifdef LECTOR_CONTADOR_TIMEOUT_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: doc/lector_contador.md
LECTOR_CONTADOR -- requirements
Module: lector_contador

Interface
REQ-001 SHALL have parameter WIDTH, default 6, the count width, matching the counter block's output.
REQ-002 SHALL have parameter TIMEOUT, default 8, the maximum number of WAIT cycles allowed per response.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a read sweep of all four counters.
REQ-006 SHALL have port valid, input, 1, the counter block's response strobe.
REQ-007 SHALL have port contador_in, input, WIDTH, the count returned with valid.
REQ-008 SHALL have port request, output, 1, the read request to the counter block.
REQ-009 SHALL have port idx, output, 2, the selected counter (0..3), stable while request is high and while awaiting valid.
REQ-010 SHALL have ports cuenta0, cuenta1, cuenta2, cuenta3, output, WIDTH each, the captured counts.
REQ-011 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse at sweep end.
REQ-013 SHALL have port error, output, 1, sticky timeout flag.

Function
REQ-014 SHALL implement the FSM states IDLE, REQ, WAIT, DONE; all outputs SHALL be registered.
REQ-015 In IDLE, start=1 SHALL clear idx to 0 and error to 0, then move to REQ; start in any other state SHALL be ignored.
REQ-016 In REQ, request SHALL be 1 for exactly one cycle, followed unconditionally by WAIT; in every other state request SHALL be 0.
REQ-017 In WAIT, valid=1 SHALL capture contador_in into cuenta[idx]. If idx<3, idx SHALL increment and the FSM SHALL go to REQ; if idx=3, it SHALL go to DONE.
REQ-018 valid received outside WAIT SHALL be ignored, with no capture and no state change.
REQ-019 Nominal latency: with start sampled at cycle T and valid arriving one cycle after each request, request SHALL be high at T+1, T+3, T+5, T+7 (idx 0..3) and done SHALL be high at T+9.
REQ-020 DONE SHALL assert done for one cycle and then return to IDLE; cuenta0..3 SHALL hold until overwritten by a later sweep or cleared by reset.
REQ-021 idx SHALL not wrap during a sweep; the idx=3 capture SHALL exit to DONE.
REQ-022 A wait-cycle counter (ceil(log2(TIMEOUT+1)) bits) SHALL clear on entry to WAIT and increment each WAIT cycle in which valid=0.

Reset
REQ-023 With reset=1 at a clock edge: state=IDLE; request=0, idx=0, cuenta0..3=0, busy=0, done=0, error=0; wait counter=0.
REQ-024 Reset SHALL take priority over start and valid, and reset during a sweep SHALL abort it with no done pulse.

Configuration
REQ-025 Macro LECTOR_CONTADOR_TIMEOUT_EN SHALL control the timeout watchdog.
REQ-026 With the macro defined: after TIMEOUT consecutive WAIT cycles with valid=0, error SHALL set (sticky), cuenta[idx] SHALL load 0, and the FSM SHALL proceed exactly as on a capture (REQ or DONE).
REQ-027 With the macro defined, if valid=1 arrives in the same cycle the timeout expires, valid SHALL win: normal capture, no error.
REQ-028 Without the macro: WAIT SHALL persist until valid, error SHALL be tied to 0, and no wait counter SHALL be synthesized.

Verification
REQ-029 Nominal sweep: counter model returns 5,9,0,63 one cycle after each request -> cuenta0..3=5,9,0,63; done at T+9; error=0.
REQ-030 Slow responder: valid 3 cycles after each request -> same counts captured; done at T+17; request never re-asserted while waiting.
REQ-031 Timeout (macro on, TIMEOUT=8): no valid for idx=2 -> error=1 after 8 WAIT cycles; cuenta2=0; idx 3 still requested; done pulses once.
REQ-032 Interference: start pulsed mid-sweep, and a spurious valid with contador_in=0x2A in IDLE -> no restart, no capture, cuenta unchanged.
REQ-033 Reset during WAIT of idx=1 -> next cycle all outputs zero, state IDLE, no done; a following start completes a clean sweep.
REQ-034 Back-to-back: start asserted in the cycle right after done -> a new sweep begins, with request high 1 cycle later and idx=0.
